// File: rtl/display_4bits_reader_pkg.sv
// Shared definitions for the seven-segment reader.
// Holds the hex glyph patterns (segments a..g, bit 0 = a), the segment bit
// positions inside the 8-bit segment bus, the settle FSM state type and the
// default stability length.
package display_4bits_reader_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Bit positions of the segment lines on the 8-bit bus.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyph patterns for hex digits 0..F on segments [6:0].
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Settle FSM: SETTLING while the run is short, STABLE for the single
  // cycle the run reaches its target length, HOLD once saturated.
  typedef enum logic [1:0] {
    ST_SETTLING = 2'b00,
    ST_STABLE   = 2'b01,
    ST_HOLD     = 2'b10
  } settle_state_e;

endpackage

// File: rtl/display_4bits_reader_glyph_decode.sv
// segment_glyph_decode: purely combinational glyph lookup.
// Ports:
//   pattern  in  7  segments a..g (bit 0 = a)
//   digit    out 4  hex value of the matching glyph, 0 when nothing matches
//   match    out 1  pattern is one of the 16 hex glyphs
//   blank    out 1  all seven segments are dark
module segment_glyph_decode
  import display_4bits_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       match,
  output logic       blank
);

  logic [3:0] digit_s;
  logic       match_s;

  // Map each glyph to its hex value; anything else is a non-match.
  always_comb begin
    digit_s = 4'h0;
    match_s = 1'b1;
    case (pattern)
      GLYPH_0: digit_s = 4'h0;
      GLYPH_1: digit_s = 4'h1;
      GLYPH_2: digit_s = 4'h2;
      GLYPH_3: digit_s = 4'h3;
      GLYPH_4: digit_s = 4'h4;
      GLYPH_5: digit_s = 4'h5;
      GLYPH_6: digit_s = 4'h6;
      GLYPH_7: digit_s = 4'h7;
      GLYPH_8: digit_s = 4'h8;
      GLYPH_9: digit_s = 4'h9;
      GLYPH_A: digit_s = 4'hA;
      GLYPH_B: digit_s = 4'hB;
      GLYPH_C: digit_s = 4'hC;
      GLYPH_D: digit_s = 4'hD;
      GLYPH_E: digit_s = 4'hE;
      GLYPH_F: digit_s = 4'hF;
      default: begin
        digit_s = 4'h0;
        match_s = 1'b0;
      end
    endcase
  end

  assign digit = digit_s;
  assign match = match_s;
  assign blank = (pattern == GLYPH_BLANK);

endmodule

// File: rtl/display_4bits_reader.sv
// display_4bits_reader: reads a seven-segment display bus, waits for the
// pattern to be stable for STABLE_CYCLES samples, decodes it to a hex digit
// and offers the result through a valid/ready holding register.
// Ports:
//   input_clock  in  1  clock, rising edge
//   input_reset  in  1  asynchronous active-high reset
//   seg_in       in  8  segments a..g on [6:0], dp on [7], active-high
//   out_ready    in  1  consumer takes the held result this cycle
//   clear_ovf    in  1  clears the sticky overflow flag
//   out_valid    out 1  a result is held
//   out_digit    out 4  decoded hex value
//   out_dp       out 1  dp bit of the decoded pattern
//   out_err      out 1  pattern was not a hex glyph
//   overflow     out 1  sticky: a result was dropped while one was held
module display_4bits_reader
  import display_4bits_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic       input_clock,
  input  logic       input_reset,
  input  logic [7:0] seg_in,
  input  logic       out_ready,
  input  logic       clear_ovf,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_dp,
  output logic       out_err,
  output logic       overflow
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  logic [7:0]    sample_r;
  logic [6:0]    prev_r;
  logic [7:0]    cnt_r;
  settle_state_e state_r;
  logic [6:0]    last_acc_r;

  logic          same_s;
  logic [7:0]    run_s;
  settle_state_e state_s;
  logic          settle_s;
  logic [3:0]    digit_s;
  logic          match_s;
  logic          blank_s;
  logic          produce_s;
  logic          transfer_s;
  logic          load_s;
  logic          drop_s;

  // cnt_r/state_r describe the run ending at prev_r; run_s/state_s extend
  // that run by the current sample, so the settle event fires in the same
  // cycle the run reaches STABLE_CYCLES.
  always_comb begin
    same_s = (sample_r[SEG_G:SEG_A] == prev_r);
    if (!same_s) begin
      run_s = 8'd1;
    end else if (cnt_r >= STABLE_LIMIT) begin
      run_s = STABLE_LIMIT;
    end else begin
      run_s = cnt_r + 8'd1;
    end
  end

  // Next settle state; STABLE only on the first cycle the run is full.
  always_comb begin
    if (run_s < STABLE_LIMIT) begin
      state_s = ST_SETTLING;
    end else if (state_r == ST_SETTLING) begin
      state_s = ST_STABLE;
    end else begin
      state_s = ST_HOLD;
    end
  end

  assign settle_s = (state_s == ST_STABLE);

  segment_glyph_decode u_decode (
    .pattern (sample_r[SEG_G:SEG_A]),
    .digit   (digit_s),
    .match   (match_s),
    .blank   (blank_s)
  );

  // A settle event only yields a result for a new, non-blank pattern.
  always_comb begin
    produce_s  = settle_s && !blank_s && (sample_r[SEG_G:SEG_A] != last_acc_r);
    transfer_s = out_valid && out_ready;
    load_s     = produce_s && (!out_valid || out_ready);
    drop_s     = produce_s && out_valid && !out_ready;
  end

  // Sample pipeline, run counter and settle FSM.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      sample_r <= 8'h00;
      prev_r   <= 7'h00;
      cnt_r    <= 8'd0;
      state_r  <= ST_SETTLING;
    end else begin
      sample_r <= seg_in;
      prev_r   <= sample_r[SEG_G:SEG_A];
      cnt_r    <= run_s;
      state_r  <= state_s;
    end
  end

  // Last-accepted pattern follows every settle event, blanks included.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      last_acc_r <= GLYPH_BLANK;
    end else if (settle_s) begin
      last_acc_r <= sample_r[SEG_G:SEG_A];
    end else begin
      last_acc_r <= last_acc_r;
    end
  end

  // Output holding register; a load may coincide with a transfer.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      out_valid <= 1'b0;
      out_digit <= 4'h0;
      out_dp    <= 1'b0;
      out_err   <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_digit <= match_s ? digit_s : 4'h0;
      out_dp    <= sample_r[SEG_DP];
      out_err   <= !match_s;
    end else if (transfer_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge input_clock or posedge input_reset) begin
    if (input_reset) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_display_4bits_reader.sv
module tb_display_4bits_reader;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg;
  logic       rdy;
  logic       clr;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_dp;
  logic       out_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_4bits_reader #(.STABLE_CYCLES(S)) dut (
    .input_clock (clk),
    .input_reset (rst),
    .seg_in      (seg),
    .out_ready   (rdy),
    .clear_ovf   (clr),
    .out_valid   (out_valid),
    .out_digit   (out_digit),
    .out_dp      (out_dp),
    .out_err     (out_err),
    .overflow    (overflow)
  );

  // Reference model: history of registered samples plus the offered result.
  logic [7:0] hist[$];
  logic       m_valid;
  logic [3:0] m_digit;
  logic       m_dp;
  logic       m_err;
  logic       m_ovf;
  logic [6:0] m_last;
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    m_valid = 1'b0; m_digit = 4'h0; m_dp = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    m_last = 7'h00;
  endtask

  // Called right after a clock edge with the inputs that were present at it.
  task automatic model_edge();
    int         run;
    logic [6:0] p;
    logic       produce;
    logic       drop;
    logic       xfer;
    logic [3:0] d;
    logic       e;
    run = 0;
    p = hist[hist.size()-1][6:0];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i][6:0] == p) run++;
      else break;
    end
    produce = 1'b0;
    if (run == S) begin
      produce = (p != m_last) && (p != 7'h00);
      m_last = p;
    end
    d = 4'h0; e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (glyphs[i] == p) begin d = 4'(i); e = 1'b0; end
    end
    xfer = m_valid && rdy;
    drop = produce && m_valid && !rdy;
    if (produce && !drop) begin
      m_valid = 1'b1; m_digit = d; m_dp = hist[hist.size()-1][7]; m_err = e;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    hist.push_back(seg);
    if (hist.size() > S + 2) void'(hist.pop_front());
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (out_valid === m_valid) else begin
      errors++; $error("FAIL %s out_valid got %0b want %0b", tag, out_valid, m_valid);
    end
    checks++;
    assert (out_digit === m_digit) else begin
      errors++; $error("FAIL %s out_digit got %0h want %0h", tag, out_digit, m_digit);
    end
    checks++;
    assert (out_dp === m_dp) else begin
      errors++; $error("FAIL %s out_dp got %0b want %0b", tag, out_dp, m_dp);
    end
    checks++;
    assert (out_err === m_err) else begin
      errors++; $error("FAIL %s out_err got %0b want %0b", tag, out_err, m_err);
    end
    checks++;
    assert (overflow === m_ovf) else begin
      errors++; $error("FAIL %s overflow got %0b want %0b", tag, overflow, m_ovf);
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic [7:0] s, input logic r, input logic c, input string tag);
    seg = s; rdy = r; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int n_res;
    logic [3:0] seen;
    rst = 1'b1; seg = 8'h00; rdy = 1'b0; clr = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();

    // Basic latency and one-cycle pulse with ready held high.
    for (int i = 0; i < 5; i++) step(8'h5B, 1'b1, 1'b0, "r030");
    expect4("r030_valid", {3'b000, out_valid}, 4'h1);
    expect4("r030_digit", out_digit, 4'h2);
    expect4("r030_err", {3'b000, out_err}, 4'h0);
    step(8'h5B, 1'b1, 1'b0, "r030_pulse");
    expect4("r030_pulse_low", {3'b000, out_valid}, 4'h0);

    // Short glitch between two identical glyphs yields a single result.
    n_res = 0; seen = 4'h0;
    for (int i = 0; i < 14; i++) begin
      step((i >= 6 && i < 8) ? 8'h07 : 8'h06, 1'b1, 1'b0, "r031");
      if (out_valid) begin n_res++; seen = out_digit; end
    end
    expect4("r031_count", 4'(n_res), 4'h1);
    expect4("r031_digit", seen, 4'h1);

    // Held result survives a dropped second result; overflow then clears.
    for (int i = 0; i < 6; i++) step(8'h3F, 1'b0, 1'b0, "r032_a");
    for (int i = 0; i < 6; i++) step(8'h06, 1'b0, 1'b0, "r032_b");
    expect4("r032_hold_digit", out_digit, 4'h0);
    expect4("r032_ovf_set", {3'b000, overflow}, 4'h1);
    step(8'h06, 1'b0, 1'b1, "r032_clr");
    expect4("r032_ovf_clr", {3'b000, overflow}, 4'h0);
    step(8'h06, 1'b1, 1'b0, "r032_drain");

    // Non-glyph, dp-carrying glyph, blank.
    for (int i = 0; i < 5; i++) step(8'h49, 1'b0, 1'b0, "r033_err");
    expect4("r033_err_flag", {3'b000, out_err}, 4'h1);
    expect4("r033_err_digit", out_digit, 4'h0);
    step(8'h49, 1'b1, 1'b0, "r033_err_drain");
    for (int i = 0; i < 5; i++) step(8'hFF, 1'b0, 1'b0, "r033_dp");
    expect4("r033_dp_digit", out_digit, 4'h8);
    expect4("r033_dp_bit", {3'b000, out_dp}, 4'h1);
    step(8'hFF, 1'b1, 1'b0, "r033_dp_drain");
    for (int i = 0; i < 7; i++) step(8'h00, 1'b1, 1'b0, "r033_blank");
    expect4("r033_blank_none", {3'b000, out_valid}, 4'h0);

    // Asynchronous reset while a result is held and a new glyph settles.
    for (int i = 0; i < 5; i++) step(8'h39, 1'b0, 1'b0, "r034_pre");
    for (int i = 0; i < 2; i++) step(8'h71, 1'b0, 1'b0, "r034_settle");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("r034_async");
    expect4("r034_digit_zero", out_digit, 4'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(8'h71, 1'b1, 1'b0, "r034_relatch");
    expect4("r034_not_early", {3'b000, out_valid}, 4'h0);
    step(8'h71, 1'b1, 1'b0, "r034_latch");
    expect4("r034_digit_f", out_digit, 4'hF);
    step(8'h71, 1'b1, 1'b0, "r034_drain");

    // Settle event coincident with a transfer.
    for (int i = 0; i < 5; i++) step(8'h4F, 1'b0, 1'b0, "r035_a");
    for (int i = 0; i < 4; i++) step(8'h66, 1'b0, 1'b0, "r035_b");
    step(8'h66, 1'b1, 1'b0, "r035_xfer");
    expect4("r035_valid", {3'b000, out_valid}, 4'h1);
    expect4("r035_digit", out_digit, 4'h4);
    expect4("r035_ovf", {3'b000, overflow}, 4'h0);
    step(8'h66, 1'b1, 1'b0, "r035_drain");

    // Randomized segment streams against the model.
    for (int k = 0; k < 200; k++) begin
      int         idx;
      int         hold;
      logic [7:0] s;
      idx = $urandom_range(0, 19);
      if (idx < 16) s = {1'($urandom_range(0, 1)), glyphs[idx]};
      else if (idx == 16) s = {1'($urandom_range(0, 1)), 7'h00};
      else s = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int j = 0; j < hold; j++)
        step(s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
